// File: rtl/prom_pkg.sv
// Shared definitions for the PROM image loader: PROM ids, window layout and FSM states.
package prom_pkg;

    // Bit positions of prom_we.
    typedef enum logic [2:0] {
        PROM16 = 3'd0,
        PROM17 = 3'd1,
        PROM18 = 3'd2,
        PROM19 = 3'd3,
        PROM20 = 3'd4,
        PROM21 = 3'd5
    } prom_e;

    localparam int PROM_COUNT = 6;

    localparam logic [24:0] REGION_START [PROM_COUNT] = '{
        25'h000, 25'h100, 25'h200, 25'h220, 25'h320, 25'h420
    };
    localparam logic [24:0] REGION_SIZE [PROM_COUNT] = '{
        25'h100, 25'h100, 25'h020, 25'h100, 25'h100, 25'h100
    };

    localparam int unsigned PROM_IMAGE_BYTES = 1312;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/prom_region_decode.sv
// Maps a window offset onto a PROM select, its local address and an in-window flag.
module prom_region_decode
    import prom_pkg::*;
(
    input  logic [24:0] offset,
    output logic [5:0]  sel,
    output logic [7:0]  local_addr,
    output logic        in_window
);

    always_comb begin
        sel        = '0;
        local_addr = '0;
        in_window  = 1'b0;
        for (int i = 0; i < PROM_COUNT; i++) begin
            if (offset >= REGION_START[i] && offset < REGION_START[i] + REGION_SIZE[i]) begin
                sel[i]     = 1'b1;
                local_addr = 8'(offset - REGION_START[i]);
                in_window  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prom_loader.sv
// Writes the six colour/timing PROM images from the ioctl download stream and
// reports whether the last image was complete.
module prom_loader
    import prom_pkg::*;
#(
    parameter logic [7:0]  INDEX = 8'd0,
    parameter logic [24:0] BASE  = 25'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [5:0]  prom_we,
    output logic [7:0]  prom_addr,
    output logic [7:0]  prom_din,
    output logic        loaded,
    output logic        load_err,
    output logic [15:0] checksum
);

    // ioctl_wr is a one-cycle strobe with no backpressure: a byte presented with
    // ioctl_wr is taken in that cycle, and prom_we is its registered one-cycle echo.
    state_e      state, state_next;
    logic        dl_q;
    logic        dl_rise, dl_fall;
    logic [10:0] count;
    logic [10:0] count_inc;
    logic [25:0] diff;
    logic        below_base;
    logic [5:0]  sel;
    logic [7:0]  local_addr;
    logic        in_window;
    logic        start, accept, check_ok;
    logic [7:0]  din_fmt;

    assign diff       = {1'b0, ioctl_addr} - {1'b0, BASE};
    assign below_base = diff[25];
    assign dl_rise    = ioctl_download && !dl_q && (ioctl_index == INDEX);
    assign dl_fall    = !ioctl_download && dl_q;
    assign count_inc  = (count == 11'h7FF) ? count : count + 11'd1;

    prom_region_decode u_decode (
        .offset     (diff[24:0]),
        .sel        (sel),
        .local_addr (local_addr),
        .in_window  (in_window)
    );

    // dl_q resets high so a download still running when reset releases is not seen as a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dl_q <= 1'b1;
        else        dl_q <= ioctl_download;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (dl_rise) state_next = ST_LOAD;
            ST_LOAD:                    if (dl_fall) state_next = ST_CHECK;
            ST_CHECK:                   state_next = check_ok ? ST_DONE : ST_ERROR;
            default:                    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        check_ok = (count == 11'(PROM_IMAGE_BYTES));
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: start = dl_rise;
            default:                    start = 1'b0;
        endcase
        accept  = ioctl_wr && in_window && !below_base && (start || state == ST_LOAD);
        din_fmt = sel[PROM18] ? ioctl_dout : {4'h0, ioctl_dout[3:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prom_we   <= '0;
            prom_addr <= '0;
            prom_din  <= '0;
            count     <= '0;
            checksum  <= '0;
            loaded    <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            prom_we <= accept ? sel : 6'b0;
            if (accept) begin
                prom_addr <= local_addr;
                prom_din  <= din_fmt;
            end
            if (start) begin
                count    <= accept ? 11'd1 : 11'd0;
                checksum <= accept ? {8'h00, din_fmt} : 16'h0000;
                loaded   <= 1'b0;
                load_err <= 1'b0;
            end else if (accept) begin
                count    <= count_inc;
                checksum <= checksum + {8'h00, din_fmt};
            end
            if (state == ST_CHECK) begin
                loaded   <= check_ok;
                load_err <= !check_ok;
            end
        end
    end

endmodule

// File: tb/tb_prom_loader.sv
// Directed bench for prom_loader: a write-level model feeds an expected queue that
// a per-cycle compare process checks; status outputs are checked at load ends.
module tb_prom_loader;

    localparam logic [7:0] IDX = 8'd0;
    localparam int IMG = 1312;
    localparam int R_START [6] = '{0, 256, 512, 544, 800, 1056};
    localparam int R_SIZE  [6] = '{256, 256, 32, 256, 256, 256};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic [5:0]  prom_we;
    logic [7:0]  prom_addr;
    logic [7:0]  prom_din;
    logic        loaded;
    logic        load_err;
    logic [15:0] checksum;

    prom_loader #(.INDEX(8'd0), .BASE(25'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .prom_we        (prom_we),
        .prom_addr      (prom_addr),
        .prom_din       (prom_din),
        .loaded         (loaded),
        .load_err       (load_err),
        .checksum       (checksum)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: {edge tag, we, addr, din}
    logic [53:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    // model state
    bit          m_loading = 1'b0;
    bit          m_dl_prev = 1'b1;
    bit          m_loaded = 1'b0;
    bit          m_err = 1'b0;
    int          m_count = 0;
    logic [15:0] m_sum = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [21:0] model_write(input int off, input logic [7:0] d);
        logic [21:0] r;
        r = '0;
        for (int p = 0; p < 6; p++) begin
            if (off >= R_START[p] && off < R_START[p] + R_SIZE[p]) begin
                r[21:16] = 6'(1 << p);
                r[15:8]  = 8'(off - R_START[p]);
                r[7:0]   = (R_SIZE[p] == 32) ? d : {4'h0, d[3:0]};
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_loading = 1'b0;
        m_dl_prev = 1'b1;
        m_loaded  = 1'b0;
        m_err     = 1'b0;
        m_count   = 0;
        m_sum     = 16'h0000;
    endtask

    // one input cycle, sampled by the next rising edge
    task automatic drive_cycle(input bit dl, input logic [7:0] idx, input bit wr,
                               input int addr, input logic [7:0] d);
        logic [21:0] w;
        @(negedge clk);
        ioctl_download = dl;
        ioctl_index    = idx;
        ioctl_wr       = wr;
        ioctl_addr     = 25'(addr);
        ioctl_dout     = d;
        if (rst_n && dl && !m_dl_prev && idx == IDX && !m_loading) begin
            m_loading = 1'b1;
            m_count   = 0;
            m_sum     = 16'h0000;
            m_loaded  = 1'b0;
            m_err     = 1'b0;
        end
        if (rst_n && m_loading && wr && addr >= 0 && addr < IMG) begin
            w = model_write(addr, d);
            exp_q.push_back({32'(cyc + 1), w});
            if (m_count < 2047) m_count++;
            m_sum = m_sum + {8'h00, w[7:0]};
        end
        if (!dl && m_dl_prev && m_loading) begin
            m_loading = 1'b0;
            m_loaded  = (m_count == IMG);
            m_err     = !m_loaded;
        end
        m_dl_prev = dl;
    endtask

    task automatic load_image(input int n, input bit fall_on_last);
        for (int i = 0; i < n; i++) begin
            drive_cycle(!(fall_on_last && i == n - 1), IDX, 1'b1, i, 8'(i));
            if (i == 1) check("loaded_clear_on_rise", {31'h0, loaded}, 32'h0);
            if (i == 'h206) begin
                check("lit_205_we", {26'h0, prom_we}, 32'h04);
                check("lit_205_addr", {24'h0, prom_addr}, 32'h05);
                check("lit_205_din", {24'h0, prom_din}, 32'h05);
            end
        end
        if (!fall_on_last) drive_cycle(1'b0, IDX, 1'b0, 0, 8'h00);
    endtask

    task automatic finish_load(input string tag);
        drive_cycle(1'b0, IDX, 1'b0, 0, 8'h00);
        check({tag, "_loaded_during_check"}, {31'h0, loaded}, 32'h0);
        drive_cycle(1'b0, IDX, 1'b0, 0, 8'h00);
        check({tag, "_loaded"}, {31'h0, loaded}, {31'h0, m_loaded});
        check({tag, "_load_err"}, {31'h0, load_err}, {31'h0, m_err});
        check({tag, "_checksum"}, {16'h0, checksum}, {16'h0, m_sum});
    endtask

    // compare process: prom_we/addr/din against the expected queue every cycle
    logic [53:0] exp_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() != 0 && exp_q[0][53:22] == cyc) begin
                exp_e = exp_q.pop_front();
                check("prom_we", {26'h0, prom_we}, {26'h0, exp_e[21:16]});
                check("prom_addr", {24'h0, prom_addr}, {24'h0, exp_e[15:8]});
                check("prom_din", {24'h0, prom_din}, {24'h0, exp_e[7:0]});
            end else begin
                check("prom_we_idle", {26'h0, prom_we}, 32'h0);
            end
        end
    end

    initial begin
        #1;
        check("rst_we", {26'h0, prom_we}, 32'h0);
        check("rst_addr", {24'h0, prom_addr}, 32'h0);
        check("rst_din", {24'h0, prom_din}, 32'h0);
        check("rst_loaded", {31'h0, loaded}, 32'h0);
        check("rst_load_err", {31'h0, load_err}, 32'h0);
        check("rst_checksum", {16'h0, checksum}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) drive_cycle(1'b0, IDX, 1'b0, 0, 8'h00);

        // full load, rise and fall both coincident with a byte
        load_image(IMG, 1'b1);
        finish_load("full");
        check("full_loaded_lit", {31'h0, loaded}, 32'h1);
        check("full_checksum_lit", {16'h0, checksum}, 32'h2770);

        // another index is ignored and leaves status alone
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'd1, 1'b1, i, 8'(i));
        repeat (3) drive_cycle(1'b0, 8'd1, 1'b0, 0, 8'h00);
        check("idx1_loaded", {31'h0, loaded}, 32'h1);
        check("idx1_load_err", {31'h0, load_err}, 32'h0);
        check("idx1_checksum", {16'h0, checksum}, 32'h2770);

        // reload after DONE
        load_image(IMG, 1'b0);
        finish_load("reload");
        check("reload_loaded_lit", {31'h0, loaded}, 32'h1);

        // out-of-window bytes plus one PROM21 byte
        drive_cycle(1'b1, IDX, 1'b1, 'h520, 8'h11);
        for (int a = 'h521; a <= 'h5FF; a++) drive_cycle(1'b1, IDX, 1'b1, a, 8'(a));
        drive_cycle(1'b1, IDX, 1'b1, 'h42A, 8'hA7);
        drive_cycle(1'b1, IDX, 1'b1, 'h5FF, 8'h55);
        check("lit_42a_we", {26'h0, prom_we}, 32'h20);
        check("lit_42a_addr", {24'h0, prom_addr}, 32'h0A);
        check("lit_42a_din", {24'h0, prom_din}, 32'h07);
        drive_cycle(1'b0, IDX, 1'b0, 0, 8'h00);
        finish_load("oow");
        check("oow_checksum_lit", {16'h0, checksum}, 32'h7);
        check("oow_load_err_lit", {31'h0, load_err}, 32'h1);

        // short load
        load_image(1000, 1'b0);
        finish_load("short");
        check("short_load_err_lit", {31'h0, load_err}, 32'h1);
        check("short_loaded_lit", {31'h0, loaded}, 32'h0);

        // reset in the middle of a load
        for (int i = 0; i <= 500; i++) drive_cycle(1'b1, IDX, 1'b1, i, 8'(i));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("mid_rst_we", {26'h0, prom_we}, 32'h0);
        check("mid_rst_addr", {24'h0, prom_addr}, 32'h0);
        check("mid_rst_din", {24'h0, prom_din}, 32'h0);
        check("mid_rst_checksum", {16'h0, checksum}, 32'h0);
        check("mid_rst_loaded", {31'h0, loaded}, 32'h0);
        for (int i = 501; i <= 505; i++) drive_cycle(1'b1, IDX, 1'b1, i, 8'(i));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 506; i <= 510; i++) drive_cycle(1'b1, IDX, 1'b1, i, 8'(i));
        repeat (2) drive_cycle(1'b0, IDX, 1'b0, 0, 8'h00);
        load_image(IMG, 1'b0);
        finish_load("after_rst");
        check("after_rst_loaded_lit", {31'h0, loaded}, 32'h1);
        check("after_rst_checksum_lit", {16'h0, checksum}, 32'h2770);

        repeat (2) drive_cycle(1'b0, IDX, 1'b0, 0, 8'h00);
        check("exp_q_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
